// File: rtl/pkg_8b10b.sv
// Shared 8b/10b definitions: K-code bytes, fixed scheduler columns and
// the scheduler state encoding.
package pkg_8b10b;

    localparam logic [7:0] K28_5 = 8'hBC;
    localparam logic [7:0] K28_0 = 8'h1C;

    typedef struct packed {
        logic [31:0] dat;
        logic [3:0]  k;
    } col_t;

    // Lane 0 carries the comma so the receiver can find byte boundaries in idle fill.
    localparam col_t IDLE_COL  = '{dat: {K28_0, K28_0, K28_0, K28_5}, k: 4'hF};
    localparam col_t ALIGN_COL = '{dat: {K28_5, K28_5, K28_5, K28_5}, k: 4'hF};

    typedef enum logic [1:0] {
        OFF   = 2'd0,
        TRAIN = 2'd1,
        RUN   = 2'd2
    } state_t;

endpackage

// File: rtl/x4_tx_scheduler_8b10b.sv
// Column scheduler feeding the x4 8b/10b encoder: training, periodic
// alignment, idle fill and valid/ready user data.
module x4_tx_scheduler_8b10b
    import pkg_8b10b::*;
#(
    parameter int unsigned TRAIN_LEN    = 16,
    parameter int unsigned ALIGN_PERIOD = 1024
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        link_en,
    input  logic [31:0] s_dat,
    input  logic [3:0]  s_k,
    input  logic        s_valid,
    output logic        s_ready,
    output logic [3:0]  kin_ena,
    output logic [31:0] ein_dat,
    output logic        link_up
);

    localparam int unsigned TW = $clog2(TRAIN_LEN + 1);
    localparam int unsigned AW = $clog2(ALIGN_PERIOD);
    localparam logic [TW-1:0] TRAIN_LAST = TW'(TRAIN_LEN - 1);
    localparam logic [AW-1:0] ALIGN_LAST = AW'(ALIGN_PERIOD - 1);

    state_t        state_q, state_d;
    logic [TW-1:0] train_cnt_q, train_cnt_d;
    logic [AW-1:0] align_cnt_q, align_cnt_d;
    col_t          col_q, col_d;
    logic          link_up_q, link_up_d;
    logic          align_slot;

    always_comb begin
        state_d     = state_q;
        train_cnt_d = train_cnt_q;
        align_cnt_d = align_cnt_q;
        col_d       = IDLE_COL;
        link_up_d   = 1'b0;

        align_slot = (state_q == RUN) && (align_cnt_q == ALIGN_LAST);
        s_ready    = link_en && (state_q == RUN) && !align_slot;

        unique case (state_q)
            OFF: begin
                train_cnt_d = '0;
                align_cnt_d = '0;
                if (link_en) begin
                    state_d = TRAIN;
                end
            end
            TRAIN: begin
                col_d       = ALIGN_COL;
                train_cnt_d = train_cnt_q + 1'b1;
                if (train_cnt_q == TRAIN_LAST) begin
                    state_d     = RUN;
                    align_cnt_d = '0;
                end
            end
            RUN: begin
                // A falling link_en already reads as down on the column emitted now.
                link_up_d   = link_en;
                align_cnt_d = align_slot ? '0 : align_cnt_q + 1'b1;
                if (align_slot) begin
                    col_d = ALIGN_COL;
                end else if (s_ready && s_valid) begin
                    col_d = '{dat: s_dat, k: s_k};
                end
            end
            default: begin
                state_d = OFF;
            end
        endcase

        if (!link_en) begin
            state_d = OFF;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q     <= OFF;
            train_cnt_q <= '0;
            align_cnt_q <= '0;
            col_q       <= IDLE_COL;
            link_up_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            train_cnt_q <= train_cnt_d;
            align_cnt_q <= align_cnt_d;
            col_q       <= col_d;
            link_up_q   <= link_up_d;
        end
    end

    assign ein_dat = col_q.dat;
    assign kin_ena = col_q.k;
    assign link_up = link_up_q;

endmodule

// File: tb/tb_x4_tx_scheduler_8b10b.sv
// Directed self-checking bench for x4_tx_scheduler_8b10b with short
// training and alignment periods.
module tb_x4_tx_scheduler_8b10b;

    localparam int unsigned TL = 4;
    localparam int unsigned AP = 8;
    localparam logic [31:0] IDLE_DAT  = 32'h1C1C1CBC;
    localparam logic [31:0] ALIGN_DAT = 32'hBCBCBCBC;

    logic        clk     = 1'b0;
    logic        rst     = 1'b0;
    logic        link_en = 1'b0;
    logic [31:0] s_dat   = '0;
    logic [3:0]  s_k     = '0;
    logic        s_valid = 1'b0;
    logic        s_ready;
    logic [3:0]  kin_ena;
    logic [31:0] ein_dat;
    logic        link_up;

    int n_checks = 0;
    int n_fail   = 0;
    int exp_cnt  = 0;

    x4_tx_scheduler_8b10b #(
        .TRAIN_LEN   (TL),
        .ALIGN_PERIOD(AP)
    ) dut (
        .clk    (clk),
        .rst    (rst),
        .link_en(link_en),
        .s_dat  (s_dat),
        .s_k    (s_k),
        .s_valid(s_valid),
        .s_ready(s_ready),
        .kin_ena(kin_ena),
        .ein_dat(ein_dat),
        .link_up(link_up)
    );

    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    // Tick while the DUT is in RUN, tracking where the alignment slot falls.
    task automatic run_tick;
        tick();
        exp_cnt = (exp_cnt == int'(AP) - 1) ? 0 : exp_cnt + 1;
    endtask

    task automatic check_col(input string tag, input logic [31:0] d, input logic [3:0] k,
                             input logic up);
        check_eq({tag, ".dat"}, ein_dat, d);
        check_eq({tag, ".k"}, 32'(kin_ena), 32'(k));
        check_eq({tag, ".up"}, 32'(link_up), 32'(up));
    endtask

    task automatic check_ready(input string tag, input logic exp);
        #1;
        check_eq({tag, ".rdy"}, 32'(s_ready), 32'(exp));
    endtask

    task automatic train_seq(input string tag);
        link_en = 1'b1;
        check_ready({tag, ".off"}, 1'b0);
        tick();
        check_col({tag, ".n0"}, IDLE_DAT, 4'hF, 1'b0);
        for (int i = 0; i < int'(TL); i++) begin
            tick();
            check_col($sformatf("%s.align%0d", tag, i), ALIGN_DAT, 4'hF, 1'b0);
            check_ready($sformatf("%s.align%0d", tag, i), i == int'(TL) - 1);
        end
        exp_cnt = 0;
    endtask

    initial begin
        logic [31:0] next_in;
        logic [31:0] next_out;
        logic        acc;

        // Reset held for three cycles, then released with the link down.
        repeat (3) tick();
        check_col("rst_hold", IDLE_DAT, 4'hF, 1'b0);
        check_ready("rst_hold", 1'b0);
        rst = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tick();
            check_col($sformatf("off%0d", i), IDLE_DAT, 4'hF, 1'b0);
            check_ready($sformatf("off%0d", i), 1'b0);
        end

        train_seq("train1");

        s_dat   = 32'h03020100;
        s_k     = 4'h0;
        s_valid = 1'b1;
        check_ready("data", 1'b1);
        run_tick();
        check_col("data", 32'h03020100, 4'h0, 1'b1);
        s_valid = 1'b0;
        s_dat   = 32'hDEADBEEF;
        run_tick();
        check_col("idle", IDLE_DAT, 4'hF, 1'b1);

        // Continuous valid: every word must come out once, in order, around ALIGN slots.
        next_in  = 32'h10000000;
        next_out = 32'h10000000;
        for (int c = 0; c < 24; c++) begin
            s_valid = 1'b1;
            s_dat   = next_in;
            s_k     = 4'h0;
            check_ready($sformatf("cad%0d", c), exp_cnt != int'(AP) - 1);
            acc = s_ready;
            if (exp_cnt == int'(AP) - 1) begin
                run_tick();
                check_col($sformatf("cad%0d.align", c), ALIGN_DAT, 4'hF, 1'b1);
            end else begin
                run_tick();
                check_col($sformatf("cad%0d.word", c), next_out, 4'h0, 1'b1);
                next_out = next_out + 1;
            end
            if (acc) next_in = next_in + 1;
        end

        // Drop the link right after an accepted beat.
        s_valid = 1'b0;
        while (exp_cnt != 3) run_tick();
        s_valid = 1'b1;
        s_dat   = 32'hCAFEF00D;
        s_k     = 4'hA;
        check_ready("drop.beat", 1'b1);
        run_tick();
        check_col("drop.beat", 32'hCAFEF00D, 4'hA, 1'b1);
        link_en = 1'b0;
        s_dat   = 32'h12345678;
        s_k     = 4'h0;
        check_ready("drop.low", 1'b0);
        tick();
        check_col("drop.idle", IDLE_DAT, 4'hF, 1'b0);
        tick();
        check_col("drop.off", IDLE_DAT, 4'hF, 1'b0);
        check_ready("drop.off", 1'b0);

        // Re-raise with valid held high: nothing accepted until training completes.
        s_dat = 32'h55AA00FF;
        train_seq("train2");
        run_tick();
        check_col("train2.first", 32'h55AA00FF, 4'h0, 1'b1);

        // Link falls exactly on the alignment slot.
        s_valid = 1'b0;
        while (exp_cnt != int'(AP) - 1) run_tick();
        link_en = 1'b0;
        check_ready("slot", 1'b0);
        tick();
        check_col("slot.align", ALIGN_DAT, 4'hF, 1'b0);
        tick();
        check_col("slot.off", IDLE_DAT, 4'hF, 1'b0);

        // Reset in the middle of a burst.
        train_seq("train3");
        s_valid = 1'b1;
        s_dat   = 32'hA0A0A0A0;
        run_tick();
        check_col("burst0", 32'hA0A0A0A0, 4'h0, 1'b1);
        s_dat = 32'hA1A1A1A1;
        run_tick();
        check_col("burst1", 32'hA1A1A1A1, 4'h0, 1'b1);
        s_dat = 32'hA2A2A2A2;
        rst   = 1'b0;
        tick();
        check_col("mid_rst", IDLE_DAT, 4'hF, 1'b0);
        check_ready("mid_rst", 1'b0);
        rst = 1'b1;
        train_seq("train4");
        run_tick();
        check_col("train4.first", 32'hA2A2A2A2, 4'h0, 1'b1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
